// File: rtl/bv_encoder_pkg.sv
// Shared types and helpers for the pipelined binary-search priority encoder.
// Stage records are sized for the widest supported vector; narrower builds use the low bits.
package bv_encoder_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int BV_WIDTH_MAX    = 64;
  localparam int COUNT_WIDTH_MAX = clog2(BV_WIDTH_MAX);

  // Width of the window a stage forwards after halving.
  function automatic int stage_window(input int width_bv, input int stage);
    return width_bv >> (stage + 1);
  endfunction

  typedef struct packed {
    logic                       valid;
    logic [BV_WIDTH_MAX-1:0]    window;
    logic [COUNT_WIDTH_MAX-1:0] idx;
    logic                       hit;
    logic                       last;
  } stage_rec_t;

  typedef enum logic {
    FE_IDLE = 1'b0,
    FE_ITER = 1'b1
  } fe_state_t;

endpackage

// File: rtl/bv_priority_encoder_pipe_if.sv
// Valid/ready bus of the priority encoder: match vector in, winning index out.
interface bv_priority_encoder_pipe_if #(
  parameter int WIDTH_BV    = 64,
  parameter int WIDTH_COUNT = 6
);
  logic                   bv_in_valid;
  logic                   bv_in_ready;
  logic [WIDTH_BV-1:0]    bv_in;
  logic                   countid_valid;
  logic                   countid_ready;
  logic [WIDTH_COUNT-1:0] countid;
  logic                   countid_hit;
  logic                   countid_last;

  modport slave (
    input  bv_in_valid, bv_in, countid_ready,
    output bv_in_ready, countid_valid, countid, countid_hit, countid_last
  );

  modport master (
    output bv_in_valid, bv_in, countid_ready,
    input  bv_in_ready, countid_valid, countid, countid_hit, countid_last
  );
endinterface

// File: rtl/bv_search_stage.sv
// One elastic halving stage: picks the priority half of the window and sets one index bit.
module bv_search_stage
  import bv_encoder_pkg::*;
#(
  parameter int WIDTH_BV     = 64,
  parameter int WIDTH_COUNT  = 6,
  parameter int STAGE        = 0,
  parameter int PRIORITY_LSB = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  stage_rec_t in_rec,
  output logic       in_ready,
  output stage_rec_t out_rec,
  input  logic       out_ready
);

  localparam int W_OUT   = stage_window(WIDTH_BV, STAGE);
  localparam int IDX_BIT = WIDTH_COUNT - 1 - STAGE;

  stage_rec_t       rec_q;
  stage_rec_t       rec_d;
  logic [W_OUT-1:0] lower;
  logic [W_OUT-1:0] upper;
  logic             sel_upper;
  logic             unused_win;

  assign lower      = in_rec.window[W_OUT-1:0];
  assign upper      = in_rec.window[2*W_OUT-1:W_OUT];
  assign unused_win = ^in_rec.window;

  // An all-zero window keeps the lower half so an empty vector resolves to index 0.
  always_comb begin
    if (PRIORITY_LSB != 0) sel_upper = (lower == '0) && (upper != '0);
    else                   sel_upper = (upper != '0);
    rec_d                  = in_rec;
    rec_d.window           = '0;
    rec_d.window[W_OUT-1:0] = sel_upper ? upper : lower;
    rec_d.idx[IDX_BIT]     = sel_upper;
  end

  assign in_ready = !rec_q.valid || out_ready;
  assign out_rec  = rec_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rec_q <= '0;
    end else if (in_ready) begin
      if (in_rec.valid) rec_q       <= rec_d;
      else              rec_q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bv_priority_encoder_pipe.sv
// Pipelined priority encoder top; define BV_MULTI_MATCH_EN to emit every set bit of each vector.
//   state   | meaning
//   FE_IDLE | waiting for a vector, bv_in_ready high
//   FE_ITER | issuing residual vector, clearing one winner bit per issue
module bv_priority_encoder_pipe
  import bv_encoder_pkg::*;
#(
  parameter int WIDTH_BV     = 64,
  parameter int WIDTH_COUNT  = 6,
  parameter int PRIORITY_LSB = 1
) (
  input logic                        clk,
  input logic                        reset,
  bv_priority_encoder_pipe_if.slave  bus
);

  stage_rec_t pipe_rec   [WIDTH_COUNT+1];
  logic       pipe_ready [WIDTH_COUNT+1];
  stage_rec_t front_rec;
  logic       unused_tail;

`ifdef BV_MULTI_MATCH_EN
  localparam logic [WIDTH_BV-1:0] ONE = {{(WIDTH_BV-1){1'b0}}, 1'b1};

  fe_state_t           state_q, state_d;
  logic [WIDTH_BV-1:0] resid_q, resid_d, resid_clr, rev, rev_clr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FE_IDLE;
      resid_q <= '0;
    end else begin
      state_q <= state_d;
      resid_q <= resid_d;
    end
  end

  // MSB priority clears the highest set bit by clearing the lowest bit of the reversed vector.
  always_comb begin
    rev       = '0;
    rev_clr   = '0;
    resid_clr = '0;
    for (int i = 0; i < WIDTH_BV; i++) rev[i] = resid_q[WIDTH_BV-1-i];
    rev_clr = rev & (rev - ONE);
    if (PRIORITY_LSB != 0) resid_clr = resid_q & (resid_q - ONE);
    else for (int i = 0; i < WIDTH_BV; i++) resid_clr[i] = rev_clr[WIDTH_BV-1-i];
  end

  always_comb begin
    state_d         = state_q;
    resid_d         = resid_q;
    front_rec       = '0;
    bus.bv_in_ready = 1'b0;
    case (state_q)
      FE_IDLE: begin
        bus.bv_in_ready = 1'b1;
        if (bus.bv_in_valid) begin
          resid_d = bus.bv_in;
          state_d = FE_ITER;
        end
      end
      FE_ITER: begin
        front_rec.valid                  = 1'b1;
        front_rec.window[WIDTH_BV-1:0]   = resid_q;
        front_rec.hit                    = |resid_q;
        front_rec.last                   = (resid_clr == '0);
        if (pipe_ready[0]) begin
          resid_d = resid_clr;
          if (resid_clr == '0) state_d = FE_IDLE;
        end
      end
      default: state_d = FE_IDLE;
    endcase
  end
`else
  always_comb begin
    front_rec                      = '0;
    front_rec.valid                = bus.bv_in_valid;
    front_rec.window[WIDTH_BV-1:0] = bus.bv_in;
    front_rec.hit                  = |bus.bv_in;
    front_rec.last                 = 1'b1;
  end

  assign bus.bv_in_ready = pipe_ready[0];
`endif

  assign pipe_rec[0]             = front_rec;
  assign pipe_ready[WIDTH_COUNT] = bus.countid_ready;

  for (genvar s = 0; s < WIDTH_COUNT; s++) begin : g_stage
    bv_search_stage #(
      .WIDTH_BV     (WIDTH_BV),
      .WIDTH_COUNT  (WIDTH_COUNT),
      .STAGE        (s),
      .PRIORITY_LSB (PRIORITY_LSB)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .in_rec    (pipe_rec[s]),
      .in_ready  (pipe_ready[s]),
      .out_rec   (pipe_rec[s+1]),
      .out_ready (pipe_ready[s+1])
    );
  end

  // The last stage register doubles as the output register.
  assign bus.countid_valid = pipe_rec[WIDTH_COUNT].valid;
  assign bus.countid       = pipe_rec[WIDTH_COUNT].idx[WIDTH_COUNT-1:0];
  assign bus.countid_hit   = pipe_rec[WIDTH_COUNT].hit;
  assign bus.countid_last  = pipe_rec[WIDTH_COUNT].last;
  assign unused_tail       = ^pipe_rec[WIDTH_COUNT];

endmodule

// File: tb/tb_bv_priority_encoder_pipe.sv
// Bench for bv_priority_encoder_pipe: LSB and MSB priority instances driven in lockstep.
module tb_bv_priority_encoder_pipe;

  localparam int WB = 64;
`ifdef BV_MULTI_MATCH_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  typedef struct {
    logic [5:0] idx;
    logic       hit;
    logic       last;
  } res_t;

  logic       clk = 1'b0;
  logic       reset;
  int         tests = 0;
  int         fails = 0;
  int         out_cnt = 0;
  res_t       q_l[$];
  res_t       q_m[$];
  bit         hold_v[2];
  logic [7:0] hold_d[2];

  always #5 clk = ~clk;

  bv_priority_encoder_pipe_if #(.WIDTH_BV(64), .WIDTH_COUNT(6)) if_l ();
  bv_priority_encoder_pipe_if #(.WIDTH_BV(64), .WIDTH_COUNT(6)) if_m ();

  bv_priority_encoder_pipe #(.WIDTH_BV(64), .WIDTH_COUNT(6), .PRIORITY_LSB(1)) u_lsb (
    .clk(clk), .reset(reset), .bus(if_l));
  bv_priority_encoder_pipe #(.WIDTH_BV(64), .WIDTH_COUNT(6), .PRIORITY_LSB(0)) u_msb (
    .clk(clk), .reset(reset), .bus(if_m));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input logic valid, input logic [63:0] v, input logic rdy);
    if_l.bv_in_valid = valid; if_l.bv_in = v; if_l.countid_ready = rdy;
    if_m.bv_in_valid = valid; if_m.bv_in = v; if_m.countid_ready = rdy;
  endtask

  // Reference: scan the vector for set bits in priority order.
  task automatic model_push(input logic [63:0] v);
    int n;
    int k;
    int lo;
    int hi;
    n = $countones(v);
    if (n == 0) begin
      q_l.push_back('{6'd0, 1'b0, 1'b1});
      q_m.push_back('{6'd0, 1'b0, 1'b1});
    end else begin
`ifdef BV_MULTI_MATCH_EN
      k = 0;
      for (int i = 0; i < WB; i++)
        if (v[i]) begin k++; q_l.push_back('{6'(i), 1'b1, k == n}); end
      k = 0;
      for (int i = WB - 1; i >= 0; i--)
        if (v[i]) begin k++; q_m.push_back('{6'(i), 1'b1, k == n}); end
`else
      lo = 0;
      hi = 0;
      for (int i = WB - 1; i >= 0; i--) if (v[i]) lo = i;
      for (int i = 0; i < WB; i++) if (v[i]) hi = i;
      q_l.push_back('{6'(lo), 1'b1, 1'b1});
      q_m.push_back('{6'(hi), 1'b1, 1'b1});
`endif
    end
  endtask

  task automatic mon_out(input int d, input logic v, input logic r, input logic [5:0] idx,
                         input logic hit, input logic last);
    logic [7:0] obs;
    res_t       e;
    obs = {idx, hit, last};
    if (v && hold_v[d]) chk(d == 0 ? "stable_l" : "stable_m", 64'(obs), 64'(hold_d[d]));
    if (v && r) begin
      if (d == 0) begin
        chk("queue_l", 64'(q_l.size() != 0), 64'd1);
        if (q_l.size() != 0) begin
          e = q_l.pop_front();
          chk("result_l", 64'(obs), 64'({e.idx, e.hit, e.last}));
          out_cnt++;
        end
      end else begin
        chk("queue_m", 64'(q_m.size() != 0), 64'd1);
        if (q_m.size() != 0) begin
          e = q_m.pop_front();
          chk("result_m", 64'(obs), 64'({e.idx, e.hit, e.last}));
        end
      end
    end
    hold_v[d] = v && !r;
    hold_d[d] = obs;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      q_l.delete();
      q_m.delete();
      hold_v[0] = 1'b0;
      hold_v[1] = 1'b0;
    end else begin
      chk("ready_pair", 64'(if_l.bv_in_ready), 64'(if_m.bv_in_ready));
      if (if_l.bv_in_valid && if_l.bv_in_ready) model_push(if_l.bv_in);
      mon_out(0, if_l.countid_valid, if_l.countid_ready, if_l.countid, if_l.countid_hit, if_l.countid_last);
      mon_out(1, if_m.countid_valid, if_m.countid_ready, if_m.countid, if_m.countid_hit, if_m.countid_last);
    end
  end

  function automatic logic [63:0] rand_vec();
    logic [63:0] a, b, c;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    c = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return 64'h1 << $urandom_range(0, 63);
      2:       return a & b & c;
      default: return a;
    endcase
  endfunction

  // Single vector into an empty pipe; result must appear exactly LAT edges after transfer.
  task automatic one_shot(input logic [63:0] v, input int exp_l, input int exp_m, input logic exp_hit);
    set_in(1'b1, v, 1'b1);
    @(posedge clk); #1;
    set_in(1'b0, '0, 1'b1);
    repeat (LAT - 2) @(posedge clk);
    @(negedge clk);
    chk("lat_early", 64'(if_l.countid_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid_l", 64'(if_l.countid_valid), 64'd1);
    chk("lat_valid_m", 64'(if_m.countid_valid), 64'd1);
    chk("idx_l", 64'(if_l.countid), 64'(exp_l));
    chk("idx_m", 64'(if_m.countid), 64'(exp_m));
    chk("hit_l", 64'(if_l.countid_hit), 64'(exp_hit));
    chk("last_l", 64'(if_l.countid_last), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int base;
    int cnt;
    int wait_cyc;

    reset = 1'b0;
    set_in(1'b0, '0, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(if_l.countid_valid), 64'd0);
    chk("rst_countid", 64'(if_l.countid), 64'd0);
    chk("rst_hit", 64'(if_l.countid_hit), 64'd0);
    chk("rst_last", 64'(if_l.countid_last), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(if_l.bv_in_ready), 64'd1);
    @(posedge clk); #1;

`ifndef BV_MULTI_MATCH_EN
    one_shot(64'h0000_0100_0000_0010, 4, 40, 1'b1);
    one_shot('1, 0, 63, 1'b1);
`endif
    one_shot(64'h0, 0, 0, 1'b0);
    one_shot(64'h1, 0, 0, 1'b1);

`ifdef BV_MULTI_MATCH_EN
    base = out_cnt;
    set_in(1'b1, 64'h8000_0000_0000_0005, 1'b1);
    @(negedge clk);
    chk("mm_ready_idle", 64'(if_l.bv_in_ready), 64'd1);
    @(posedge clk); #1;
    set_in(1'b0, '0, 1'b1);
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_l.bv_in_ready) break;
      busy++;
    end
    chk("mm_busy_cycles", 64'(busy), 64'd3);
    for (int i = 0; i < 20 && out_cnt - base < 3; i++) @(posedge clk);
    @(negedge clk);
    chk("mm_result_count", 64'(out_cnt - base), 64'd3);
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 3) != 0, rand_vec(), $urandom_range(0, 1) != 0);
      @(posedge clk); #1;
    end
    set_in(1'b0, '0, 1'b1);
    wait_cyc = 0;
    while ((q_l.size() != 0 || q_m.size() != 0 || if_l.countid_valid) && wait_cyc < 3000) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    @(negedge clk);
    chk("drain_left", 64'(q_l.size() + q_m.size()), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, rand_vec() | 64'h2, 1'b0);
      @(posedge clk); #1;
    end
    set_in(1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    set_in(1'b0, '0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if_l.countid_valid || if_m.countid_valid) cnt++;
    end
    chk("flush_valid", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    one_shot(64'h1, 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
